// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, counter width and the
// default base address.
package dmem_pkg;

    localparam int unsigned CntWidth        = 4;
    localparam logic [31:0] DefaultBaseAddr = 32'h1001_0000;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } dmem_state_e;

    // Word offset of a byte address relative to the base of the array.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, asynchronous read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder with programmable wait states. Defining
// DMEM_ALIGN_CHECK_EN adds the Misaligned_o port and rejects non-word-aligned accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 64,
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDR    = DefaultBaseAddr
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Read_i,
    input  logic        Mem_Write_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Stall_o,
    output logic        Ready_o
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        Misaligned_o
`endif
);

    localparam int unsigned         AddrW    = $clog2(MEMORY_DEPTH);
    localparam logic [CntWidth-1:0] WaitInit = CntWidth'(WAIT_STATES);

    dmem_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [AddrW-1:0]    idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                is_wr_q, is_wr_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;

    logic             req;
    logic             misaligned_req;
    logic [AddrW-1:0] req_idx;
    logic [AddrW-1:0] mem_idx;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_we;

    assign req     = Mem_Read_i | Mem_Write_i;
    assign req_idx = AddrW'(word_offset(Address_i, BASE_ADDR));

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned_req = |Address_i[1:0];
`else
    assign misaligned_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = idx_q;
        mem_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d     = req_idx;
                    wdata_d   = Write_Data_i;
                    is_wr_d   = Mem_Write_i;
                    cnt_d     = WaitInit;
                    // Zero-wait accesses complete straight from IDLE using the live inputs.
                    mem_idx   = req_idx;
                    mem_wdata = Write_Data_i;
                    if (misaligned_req) begin
                        state_d = StDone;
                        ready_d = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StDone;
                        ready_d = 1'b1;
                        mem_we  = Mem_Write_i;
                        if (!Mem_Write_i) begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CntWidth'(1)) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    mem_we  = is_wr_q;
                    if (!is_wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q, mis_d;

    assign mis_d = (state_q == StIdle) & req & misaligned_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign Misaligned_o = mis_q;
`endif

    // Gated by reset so the stall drops immediately even with a request held.
    assign Stall_o     = reset & (((state_q == StIdle) & req) | (state_q == StWait));
    assign Ready_o     = ready_q;
    assign Read_Data_o = rdata_q;

    dmem_array #(
        .Depth (MEMORY_DEPTH),
        .AddrW (AddrW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (mem_idx),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd2, wr2, rd0, wr0;
    logic [31:0] addr2, wdata2, addr0, wdata0;
    logic [31:0] rdata2, rdata0;
    logic        stall2, stall0, rdy2, rdy0;
    logic        mis2, mis0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .MEMORY_DEPTH (64),
        .WAIT_STATES  (2),
        .BASE_ADDR    (32'h1001_0000)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .Mem_Read_i   (rd2),
        .Mem_Write_i  (wr2),
        .Address_i    (addr2),
        .Write_Data_i (wdata2),
        .Read_Data_o  (rdata2),
        .Stall_o      (stall2),
`ifdef DMEM_ALIGN_CHECK_EN
        .Misaligned_o (mis2),
`endif
        .Ready_o      (rdy2)
    );

    data_mem_responder #(
        .MEMORY_DEPTH (64),
        .WAIT_STATES  (0),
        .BASE_ADDR    (32'h1001_0000)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .Mem_Read_i   (rd0),
        .Mem_Write_i  (wr0),
        .Address_i    (addr0),
        .Write_Data_i (wdata0),
        .Read_Data_o  (rdata0),
        .Stall_o      (stall0),
`ifdef DMEM_ALIGN_CHECK_EN
        .Misaligned_o (mis0),
`endif
        .Ready_o      (rdy0)
    );

`ifndef DMEM_ALIGN_CHECK_EN
    assign mis2 = 1'b0;
    assign mis0 = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the Ready cycle.
    task automatic access(input bit slow, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_stalls, input int exp_cyc, input string tag,
                          output logic [31:0] rdat, output logic mis);
        int   stalls;
        int   cyc;
        logic rdy;
        logic stl;
        if (slow) begin
            rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
        end else begin
            rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
        end
        stalls = 0;
        cyc    = 0;
        rdy    = 1'b0;
        stl    = 1'b0;
        while (!rdy && cyc < 20) begin
            #1;
            cyc++;
            rdy = slow ? rdy2 : rdy0;
            stl = slow ? stall2 : stall0;
            if (!rdy) begin
                if (stl) stalls++;
                @(negedge clk);
            end
        end
        rdat = slow ? rdata2 : rdata0;
        mis  = slow ? mis2 : mis0;
        check_eq({tag, "_stalls"}, stalls, exp_stalls);
        check_eq({tag, "_ready_cycle"}, cyc, exp_cyc);
        check_eq({tag, "_stall_in_done"}, {31'd0, stl}, 32'd0);
        rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] rdat;
    logic        mis;
    int          n;

    initial begin
        reset = 1'b0;
        rd2 = 1'b1; wr2 = 1'b0; addr2 = 32'h1001_0000; wdata2 = '0;
        rd0 = 1'b1; wr0 = 1'b0; addr0 = 32'h1001_0000; wdata0 = '0;
        #12;
        check_eq("rst_stall2", {31'd0, stall2}, 32'd0);
        check_eq("rst_ready2", {31'd0, rdy2}, 32'd0);
        check_eq("rst_rdata2", rdata2, 32'd0);
        check_eq("rst_stall0", {31'd0, stall0}, 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        rd2 = 1'b0; rd0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write then read back with two wait states
        access(1, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, 3, 4, "wr_w1", rdat, mis);
        #1 check_eq("ready_one_cycle", {31'd0, rdy2}, 32'd0);
        access(1, 1, 0, 32'h1001_0004, 32'h0, 3, 4, "rd_w1", rdat, mis);
        check_eq("rd_w1_data", rdat, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        #1 check_eq("rd_hold", rdata2, 32'hDEAD_BEEF);

        // Read+write together acts as a write and leaves Read_Data_o alone
        access(1, 1, 1, 32'h1001_0008, 32'h5555_AAAA, 3, 4, "rdwr_w2", rdat, mis);
        check_eq("rdwr_rdata_kept", rdat, 32'hDEAD_BEEF);
        access(1, 1, 0, 32'h1001_0008, 32'h0, 3, 4, "rd_w2", rdat, mis);
        check_eq("rd_w2_data", rdat, 32'h5555_AAAA);

        // Out-of-range address wraps modulo depth
        access(1, 0, 1, 32'h1001_0100, 32'h0BAD_F00D, 3, 4, "wr_wrap", rdat, mis);
        access(1, 1, 0, 32'h1001_0000, 32'h0, 3, 4, "rd_w0", rdat, mis);
        check_eq("rd_w0_data", rdat, 32'h0BAD_F00D);
        access(1, 1, 0, 32'h1001_0104, 32'h0, 3, 4, "rd_wrap_w1", rdat, mis);
        check_eq("rd_wrap_w1_data", rdat, 32'hDEAD_BEEF);

        // Request dropped mid-access still completes
        wr2 = 1'b1; addr2 = 32'h1001_0010; wdata2 = 32'h7777_0004;
        @(negedge clk);
        wr2 = 1'b0;
        n = 0;
        #1;
        while (!rdy2 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("drop_req_ready_cycle", n, 2);
        @(negedge clk);
        access(1, 1, 0, 32'h1001_0010, 32'h0, 3, 4, "rd_w4", rdat, mis);
        check_eq("rd_w4_data", rdat, 32'h7777_0004);

        // Reset during WAIT aborts the write
        access(1, 0, 1, 32'h1001_000C, 32'h1111_3333, 3, 4, "wr_w3", rdat, mis);
        wr2 = 1'b1; addr2 = 32'h1001_000C; wdata2 = 32'h1234_5678;
        @(negedge clk);
        #1 check_eq("in_wait_stall", {31'd0, stall2}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_stall", {31'd0, stall2}, 32'd0);
        check_eq("abort_ready", {31'd0, rdy2}, 32'd0);
        check_eq("abort_rdata", rdata2, 32'd0);
        wr2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access(1, 1, 0, 32'h1001_000C, 32'h0, 3, 4, "rd_w3", rdat, mis);
        check_eq("rd_w3_unchanged", rdat, 32'h1111_3333);

        // Zero wait states: two writes then back-to-back reads
        access(0, 0, 1, 32'h1001_0014, 32'hA5A5_0005, 1, 2, "f_wr_w5", rdat, mis);
        access(0, 0, 1, 32'h1001_0018, 32'h0606_0606, 1, 2, "f_wr_w6", rdat, mis);
        access(0, 1, 0, 32'h1001_0014, 32'h0, 1, 2, "f_rd_w5", rdat, mis);
        check_eq("f_rd_w5_data", rdat, 32'hA5A5_0005);
        access(0, 1, 0, 32'h1001_0018, 32'h0, 1, 2, "f_rd_w6", rdat, mis);
        check_eq("f_rd_w6_data", rdat, 32'h0606_0606);

`ifdef DMEM_ALIGN_CHECK_EN
        access(1, 0, 1, 32'h1001_0002, 32'hFFFF_FFFF, 1, 2, "mis_wr", rdat, mis);
        check_eq("mis_wr_flag", {31'd0, mis}, 32'd1);
        access(1, 1, 0, 32'h1001_0000, 32'h0, 3, 4, "rd_w0_after_mis", rdat, mis);
        check_eq("rd_w0_after_mis_data", rdat, 32'h0BAD_F00D);
        check_eq("aligned_no_flag", {31'd0, mis}, 32'd0);
        access(1, 1, 0, 32'h1001_0004, 32'h0, 3, 4, "rd_w1_again", rdat, mis);
        access(1, 1, 0, 32'h1001_0001, 32'h0, 1, 2, "mis_rd", rdat, mis);
        check_eq("mis_rd_flag", {31'd0, mis}, 32'd1);
        check_eq("mis_rd_rdata_kept", rdat, 32'hDEAD_BEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEMORY_DEPTH, default 64, number of 32-bit words in the backing array (power of two).
REQ-002 Parameter WAIT_STATES, default 2, extra stall cycles per access (range 0..15).
REQ-003 Parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Mem_Read_i  input  1  load request from the control path, level, held until Ready_o.
REQ-007 Mem_Write_i  input  1  store request from the control path, level, held until Ready_o.
REQ-008 Address_i  input  32  byte address from the ALU.
REQ-009 Write_Data_i  input  32  store data, sampled with the request.
REQ-010 Read_Data_o  output  32  registered load data, held until the next completed load.
REQ-011 Stall_o  output  1  freezes PC/pipeline while the access is pending.
REQ-012 Ready_o  output  1  one-cycle completion pulse.
REQ-013 Misaligned_o  output  1  one-cycle error pulse with Ready_o (present only with ALIGN_CHECK_EN).

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 In IDLE, a request (Mem_Read_i or Mem_Write_i) SHALL latch address, data and type, load the wait counter with WAIT_STATES, and move to WAIT (WAIT_STATES>0) or DONE (WAIT_STATES=0).
REQ-016 Stall_o SHALL be combinational: high in IDLE with a request present, and high throughout WAIT; low in DONE.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at the edge where it reaches 1, the FSM SHALL move to DONE.
REQ-018 Each access SHALL stall for exactly WAIT_STATES+1 cycles, with Ready_o high for exactly one cycle (DONE) and DONE always followed by IDLE.
REQ-019 A write SHALL commit to the array on the edge entering DONE, using the latched data.
REQ-020 A read SHALL load Read_Data_o on the edge entering DONE.
REQ-021 Requests present during DONE SHALL be ignored; only IDLE accepts a new request.
REQ-022 If Mem_Read_i and Mem_Write_i are both high, the access SHALL be treated as a write and Read_Data_o SHALL be unchanged.
REQ-023 Word index = (Address_i - BASE_ADDR) >> 2, truncated to log2(MEMORY_DEPTH) bits; out-of-range addresses SHALL wrap modulo MEMORY_DEPTH.
REQ-024 Request signals deasserted mid-access SHALL NOT abort it; the latched access completes.

Reset
REQ-025 On reset low: state=IDLE, counter=0, Read_Data_o=0, Ready_o=0, Misaligned_o=0, Stall_o=0, regardless of clk.
REQ-026 Reset during WAIT SHALL abort the access without committing the write.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: Address_i[1:0]!=0 SHALL go directly to DONE (one stall cycle), suppress the write, leave Read_Data_o unchanged, and pulse Misaligned_o with Ready_o.
REQ-029 Macro undefined: Misaligned_o port absent, Address_i[1:0] ignored, all accesses treated as word-aligned.

Structure
REQ-030 A shared package dmem_pkg SHALL hold the state encoding, the default BASE_ADDR, and the counter width (4).
REQ-031 The storage SHALL be a sub-module dmem_array (single port, synchronous write, asynchronous read, MEMORY_DEPTH x 32).

Verification
REQ-032 WAIT_STATES=2; write 32'hDEAD_BEEF at 32'h1001_0004 -> Stall_o high 3 cycles, Ready_o pulse on 4th cycle, word 1 = DEAD_BEEF.
REQ-033 Read back 32'h1001_0004 -> Read_Data_o=32'hDEAD_BEEF in DONE, held through following non-load cycles.
REQ-034 WAIT_STATES=0; read -> Stall_o high for 1 cycle, Ready_o next cycle; back-to-back reads each complete in 2 cycles.
REQ-035 Reset pulsed during WAIT of a write of 32'h1234_5678 to word 3 -> word 3 unchanged, all outputs 0, FSM in IDLE.
REQ-036 With DMEM_ALIGN_CHECK_EN, write to 32'h1001_0002 -> Misaligned_o and Ready_o pulse together, no array change; address 32'h1001_0100 with depth 64 -> wraps to word 0.
